// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - recovers hex digits from a scanned 8-digit seven-segment display bus
// A digit is captured once its strobe and pattern stay stable long enough; eight captures form one frame.
module seven_segment_decoder #(
    parameter bit          ENABLE_ACTIVE_LOW  = 1'b1,
    parameter bit          SEGMENT_ACTIVE_LOW = 1'b1,
    parameter int unsigned SETTLE_CYCLES      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  digit_enable_i,
    input  logic [7:0]  digit_code_i,
    output logic [31:0] value_o,
    output logic [7:0]  dp_o,
    output logic        valid_o,
    output logic        error_o
);

    localparam logic [7:0] EN_IDLE    = ENABLE_ACTIVE_LOW  ? 8'hFF : 8'h00;
    localparam logic [7:0] SEG_IDLE   = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] SETTLE_TGT = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  en_pin_q, en_pin_d;
    logic [7:0]  code_pin_q, code_pin_d;
    logic [7:0]  prev_en_q, prev_en_d;
    logic [7:0]  prev_seg_q, prev_seg_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] shadow_val_q, shadow_val_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  dp_q, dp_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    logic [7:0]  en;
    logic [7:0]  seg;
    logic        en_blank;
    logic        en_onehot;
    logic        en_bad;
    logic        same;
    logic [2:0]  dig_idx;
    logic [4:0]  dec;
    logic        load;
    logic        capture;

    // Returns {decodable, nibble} for a gfedcba pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        en        = en_pin_q ^ EN_IDLE;
        seg       = code_pin_q ^ SEG_IDLE;
        en_blank  = (en == 8'h00);
        en_onehot = !en_blank && ((en & (en - 8'd1)) == 8'h00);
        en_bad    = !en_blank && !en_onehot;
        same      = ({en, seg} == {prev_en_q, prev_seg_q});
        dec       = decode_seg(seg[6:0]);
        dig_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (en[i]) dig_idx = 3'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        en_pin_d     = digit_enable_i;
        code_pin_d   = digit_code_i;
        prev_en_d    = en;
        prev_seg_d   = seg;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        value_d      = value_q;
        dp_d         = dp_q;
        valid_d      = 1'b0;
        error_d      = 1'b0;
        load         = 1'b0;
        capture      = 1'b0;

        if (en_bad) begin
            error_d = 1'b1;
            mask_d  = 8'h00;
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_onehot) load = 1'b1;
                end
                SETTLE: begin
                    if (same) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == SETTLE_TGT) capture = 1'b1;
                    end else if (en_onehot) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end
                HOLD: begin
                    if (en_blank) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else if (en != prev_en_q) begin
                        load = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // A freshly selected digit counts as its first stable cycle.
        if (load) begin
            state_d = SETTLE;
            cnt_d   = 8'd1;
            if (SETTLE_TGT == 8'd1) capture = 1'b1;
        end

        if (capture) begin
            state_d = HOLD;
            if (!dec[4]) begin
                error_d = 1'b1;
                mask_d  = 8'h00;
            end else begin
                shadow_val_d[{dig_idx, 2'b00} +: 4] = dec[3:0];
                shadow_dp_d[dig_idx]                = seg[7];
                mask_d                              = mask_q | (8'd1 << dig_idx);
                if (mask_d == 8'hFF) begin
                    value_d = shadow_val_d;
                    dp_d    = shadow_dp_d;
                    valid_d = 1'b1;
                    mask_d  = 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            en_pin_q     <= EN_IDLE;
            code_pin_q   <= SEG_IDLE;
            prev_en_q    <= 8'h00;
            prev_seg_q   <= 8'h00;
            cnt_q        <= 8'd0;
            mask_q       <= 8'h00;
            shadow_val_q <= 32'h0;
            shadow_dp_q  <= 8'h00;
            value_q      <= 32'h0;
            dp_q         <= 8'h00;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_pin_q     <= en_pin_d;
            code_pin_q   <= code_pin_d;
            prev_en_q    <= prev_en_d;
            prev_seg_q   <= prev_seg_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
        end
    end

    assign value_o = value_q;
    assign dp_o    = dp_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - randomized scoreboard bench for seven_segment_decoder
module tb_seven_segment_decoder;

    localparam int S = 4;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int          edge_n;
        bit          is_err;
        logic [31:0] val;
        logic [7:0]  dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  digit_enable_i = 8'hFF;
    logic [7:0]  digit_code_i = 8'hFF;
    logic [31:0] value_o;
    logic [7:0]  dp_o;
    logic        valid_o;
    logic        error_o;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic        rst_at_edge = 1'b1;
    logic [31:0] held_val = 32'h0;
    logic [7:0]  held_dp = 8'h00;

    logic [7:0]  m_mask = 8'h00;
    logic [31:0] m_val = 32'h0;
    logic [7:0]  m_dp = 8'h00;
    logic [7:0]  last_en = 8'h00;

    seven_segment_decoder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .digit_enable_i (digit_enable_i),
        .digit_code_i   (digit_code_i),
        .value_o        (value_o),
        .dp_o           (dp_o),
        .valid_o        (valid_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt    <= edge_cnt + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    function automatic int ref_decode(input logic [6:0] s);
        for (int v = 0; v < 16; v++) begin
            if (SEG_TAB[v] == s) return v;
        end
        return -1;
    endfunction

    task automatic drive(input logic [7:0] en_pins, input logic [7:0] code_pins, input int len);
        digit_enable_i = en_pins;
        digit_code_i   = code_pins;
        repeat (len) @(negedge clk);
    endtask

    // en and seg are active-high; the pins carry their complements.
    task automatic apply(input logic [7:0] en, input logic [7:0] seg, input int len);
        int   n;
        int   ones;
        int   idx;
        int   v;
        exp_t e;
        ones = $countones(en);
        if (ones == 1 && en == last_en) drive(8'hFF, 8'hFF, 1);
        n = edge_cnt + 1;
        e.val = 32'h0;
        e.dp  = 8'h00;
        if (ones == 1) begin
            if (len >= S) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (en[i]) idx = i;
                v = ref_decode(seg[6:0]);
                e.edge_n = n + S;
                if (v < 0) begin
                    e.is_err = 1'b1;
                    exp_q.push_back(e);
                    m_mask = 8'h00;
                end else begin
                    m_val[idx*4 +: 4] = 4'(v);
                    m_dp[idx]         = seg[7];
                    m_mask[idx]       = 1'b1;
                    if (m_mask == 8'hFF) begin
                        e.is_err = 1'b0;
                        e.val    = m_val;
                        e.dp     = m_dp;
                        exp_q.push_back(e);
                        m_mask = 8'h00;
                    end
                end
            end
        end else if (ones > 1) begin
            for (int k = 0; k < len; k++) begin
                e.edge_n = n + 1 + k;
                e.is_err = 1'b1;
                exp_q.push_back(e);
            end
            m_mask = 8'h00;
        end
        last_en = en;
        drive(~en, ~seg, len);
    endtask

    task automatic put_digit(input int d, input logic [3:0] v, input logic dp, input int len);
        apply(8'(1 << d), {dp, SEG_TAB[v]}, len);
    endtask

    task automatic full_scan(input logic [31:0] vals, input logic [7:0] dps, input int hold);
        for (int d = 0; d < 8; d++) put_digit(d, vals[4*d +: 4], dps[d], hold);
    endtask

    task automatic do_reset();
        apply(8'h00, 8'h00, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_value_o", value_o, 0);
        check("reset_dp_o", dp_o, 0);
        check("reset_valid_o", valid_o, 0);
        check("reset_error_o", error_o, 0);
        rst     = 1'b0;
        m_mask  = 8'h00;
        last_en = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rst_at_edge) begin
            held_val = 32'h0;
            held_dp  = 8'h00;
        end
        check("valid_error_exclusive", 64'(valid_o & error_o), 0);
        if (valid_o || error_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {valid_o, error_o}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_edge", edge_cnt, mon_e.edge_n);
                check("event_is_error", error_o, mon_e.is_err);
                if (!mon_e.is_err) begin
                    held_val = mon_e.val;
                    held_dp  = mon_e.dp;
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
            check("missed_event_edge", 0, exp_q[0].edge_n);
            void'(exp_q.pop_front());
        end
        check("value_o", value_o, held_val);
        check("dp_o", dp_o, held_dp);
    end

    initial begin
        int          r;
        int          seq;
        logic [7:0]  en;
        logic [31:0] vals;

        @(negedge clk);
        do_reset();

        full_scan(32'hFDECBA98, 8'h00, 16);
        apply(8'h00, 8'h00, 4);
        check("scan_value", value_o, 32'hFDECBA98);
        check("scan_dp", dp_o, 8'h00);

        for (int d = 0; d < 8; d++) put_digit(d, 4'(d + 1), 1'b0, (d == 3) ? 2 : 16);
        full_scan(32'h01234567, 8'hA5, 16);

        put_digit(0, 4'h1, 1'b0, 16);
        put_digit(1, 4'h2, 1'b0, 16);
        apply(8'h04, 8'h49, 16);
        for (int d = 3; d < 8; d++) put_digit(d, 4'(d), 1'b1, 16);
        full_scan(32'h89ABCDEF, 8'h3C, 16);

        put_digit(0, 4'h7, 1'b0, 8);
        apply(8'b0000_0011, 8'h00, 1);
        put_digit(1, 4'h6, 1'b0, 8);

        for (int d = 0; d < 5; d++) put_digit(d, 4'h5, 1'b0, 16);
        do_reset();
        for (int d = 5; d < 8; d++) put_digit(d, 4'h5, 1'b0, 16);
        full_scan(32'h13579BDF, 8'hFF, 6);

        seq = 0;
        for (int it = 0; it < 400; it++) begin
            if (it % 40 == 0) begin
                vals = $urandom;
                full_scan(vals, 8'($urandom), $urandom_range(S, 8));
            end
            r = $urandom_range(0, 99);
            if (r < 70) begin
                if ($urandom_range(0, 4) != 0) seq = (seq + 1) % 8;
                else seq = $urandom_range(0, 7);
                put_digit(seq, 4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(1, 10));
            end else if (r < 78) begin
                apply(8'(1 << $urandom_range(0, 7)), 8'($urandom), $urandom_range(4, 8));
            end else if (r < 90) begin
                apply(8'h00, 8'h00, $urandom_range(1, 3));
            end else if (r < 98) begin
                en = 8'($urandom);
                while ($countones(en) < 2) en = 8'($urandom);
                apply(en, 8'($urandom), $urandom_range(1, 2));
            end else begin
                do_reset();
            end
        end

        apply(8'h00, 8'h00, 8);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
